// File: rtl/prio_enc_pkg.sv
// Shared constants, types and the index-width helper for the priority encoder.
// Used by both builds (with and without PRIO_ENC_ONEHOT_EN).
package prio_enc_pkg;

  localparam int DEF_IN_W = 4;

  // Index width that stays at least 1 bit even for very small input widths.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [idx_width(DEF_IN_W)-1:0] idx_def_t;

endpackage

// File: rtl/prio_enc_core.sv
// Combinational MSB-first priority scan: index of highest set bit, any-set flag,
// and (with PRIO_ENC_ONEHOT_EN) the input masked down to its highest set bit.
module prio_enc_core
  import prio_enc_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  localparam int OUT_W = idx_width(IN_W)
) (
  input  logic [IN_W-1:0]  data_in,
  output logic [OUT_W-1:0] idx,
`ifdef PRIO_ENC_ONEHOT_EN
  output logic [IN_W-1:0]  onehot,
`endif
  output logic             any
);

  // Scanning upward lets the last hit (highest bit) overwrite earlier ones.
  always_comb begin
    idx = '0;
    any = 1'b0;
`ifdef PRIO_ENC_ONEHOT_EN
    onehot = '0;
`endif
    for (int i = 0; i < IN_W; i++) begin
      if (data_in[i]) begin
        idx = OUT_W'(i);
        any = 1'b1;
`ifdef PRIO_ENC_ONEHOT_EN
        onehot    = '0;
        onehot[i] = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/priority_encoder_4to2_sync.sv
// Registered priority encoder (one-cycle latency, synchronous active-high reset).
// Optional onehot_out port is enabled by defining PRIO_ENC_ONEHOT_EN.
module priority_encoder_4to2_sync
  import prio_enc_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  localparam int OUT_W = idx_width(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  data_in,
  output logic [OUT_W-1:0] encoded_out,
`ifdef PRIO_ENC_ONEHOT_EN
  output logic [IN_W-1:0]  onehot_out,
`endif
  output logic             valid
);

  logic [OUT_W-1:0] idx_next;
  logic             any_next;
`ifdef PRIO_ENC_ONEHOT_EN
  logic [IN_W-1:0]  onehot_next;
`endif

  prio_enc_core #(
    .IN_W (IN_W)
  ) u_core (
    .data_in (data_in),
    .idx     (idx_next),
`ifdef PRIO_ENC_ONEHOT_EN
    .onehot  (onehot_next),
`endif
    .any     (any_next)
  );

  // Reset wins over the sample taken on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      encoded_out <= '0;
      valid       <= 1'b0;
`ifdef PRIO_ENC_ONEHOT_EN
      onehot_out  <= '0;
`endif
    end else begin
      encoded_out <= idx_next;
      valid       <= any_next;
`ifdef PRIO_ENC_ONEHOT_EN
      onehot_out  <= onehot_next;
`endif
    end
  end

endmodule

// File: tb/tb_priority_encoder_4to2_sync.sv
// Self-checking bench for priority_encoder_4to2_sync (also covers PRIO_ENC_ONEHOT_EN when defined).
// Arithmetic reference model checked every cycle, plus hand-computed literal expectations.
module tb_priority_encoder_4to2_sync;

  logic       clk;
  logic       rst;
  logic [3:0] data_in;
  logic [1:0] encoded_out;
  logic       valid;
`ifdef PRIO_ENC_ONEHOT_EN
  logic [3:0] onehot_out;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  priority_encoder_4to2_sync dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .encoded_out (encoded_out),
`ifdef PRIO_ENC_ONEHOT_EN
    .onehot_out  (onehot_out),
`endif
    .valid       (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Highest set bit of a nonzero value d is floor(log2(d)) = clog2(d+1)-1.
  function automatic int model_idx(input logic [3:0] d);
    int v;
    v = int'(d);
    return (v == 0) ? 0 : $clog2(v + 1) - 1;
  endfunction

  logic       model_ready = 1'b0;
  logic [1:0] exp_enc;
  logic       exp_valid;
  logic [3:0] exp_onehot;

  always @(posedge clk) begin
    model_ready <= 1'b1;
    if (rst || data_in == 4'd0) begin
      exp_enc    <= 2'd0;
      exp_valid  <= 1'b0;
      exp_onehot <= 4'd0;
    end else begin
      exp_enc    <= 2'(model_idx(data_in));
      exp_valid  <= 1'b1;
      exp_onehot <= 4'(1 << model_idx(data_in));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ready) begin
      tests_run++;
      if (encoded_out !== exp_enc || valid !== exp_valid) begin
        tests_failed++;
        $display("FAIL model_cycle t=%0t data_in=%b enc=%0d valid=%0b required enc=%0d valid=%0b",
                 $time, data_in, encoded_out, valid, exp_enc, exp_valid);
      end
`ifdef PRIO_ENC_ONEHOT_EN
      tests_run++;
      if (onehot_out !== exp_onehot) begin
        tests_failed++;
        $display("FAIL model_onehot t=%0t onehot=%b required %b", $time, onehot_out, exp_onehot);
      end
`endif
    end
  end

  // Apply one vector, let one edge pass, and leave time for outputs to settle.
  task automatic step(input logic [3:0] d, input logic r);
    data_in = d;
    rst     = r;
    @(posedge clk);
    #2;
  endtask

  task automatic check_lit(input string name, input logic [1:0] enc, input logic v);
    tests_run++;
    if (encoded_out !== enc || valid !== v) begin
      tests_failed++;
      $display("FAIL %s enc=%0d valid=%0b required enc=%0d valid=%0b", name, encoded_out, valid, enc, v);
    end
    $display("[TB] %s data_in=%b rst=%0b -> enc=%0d valid=%0b", name, data_in, rst, encoded_out, valid);
  endtask

`ifdef PRIO_ENC_ONEHOT_EN
  task automatic check_oh(input string name, input logic [3:0] oh);
    tests_run++;
    if (onehot_out !== oh) begin
      tests_failed++;
      $display("FAIL %s onehot=%b required %b", name, onehot_out, oh);
    end
  endtask
`endif

  logic [3:0] onehot_vec [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] multi_vec  [4] = '{4'b1010, 4'b1111, 4'b0110, 4'b0011};
  logic [1:0] multi_exp  [4] = '{2'd3, 2'd3, 2'd2, 2'd1};

  initial begin
    rst     = 1'b1;
    data_in = 4'b1111;

    step(4'b1111, 1'b1); check_lit("reset_1", 2'd0, 1'b0);
    step(4'b1111, 1'b1); check_lit("reset_2", 2'd0, 1'b0);
    step(4'b1111, 1'b0); check_lit("release", 2'd3, 1'b1);

    step(4'b0000, 1'b0); check_lit("zero", 2'd0, 1'b0);
`ifdef PRIO_ENC_ONEHOT_EN
    check_oh("zero_oh", 4'b0000);
`endif

    for (int i = 0; i < 4; i++) begin
      step(onehot_vec[i], 1'b0);
      check_lit($sformatf("onehot_%0d", i), 2'(i), 1'b1);
    end

    for (int i = 0; i < 4; i++) begin
      step(multi_vec[i], 1'b0);
      check_lit($sformatf("multi_%b", multi_vec[i]), multi_exp[i], 1'b1);
    end

`ifdef PRIO_ENC_ONEHOT_EN
    step(4'b1010, 1'b0); check_oh("oh_1010", 4'b1000);
`endif

    step(4'b1000, 1'b0); check_lit("mid_pre", 2'd3, 1'b1);
    step(4'b1000, 1'b1); check_lit("mid_rst", 2'd0, 1'b0);
    step(4'b0110, 1'b0); check_lit("mid_resume", 2'd2, 1'b1);

    // Exhaustive sweep; the per-cycle model check covers each value.
    for (int v = 0; v < 16; v++) begin
      step(4'(v), 1'b0);
      $display("[TB] sweep data_in=%b -> enc=%0d valid=%0b", data_in, encoded_out, valid);
    end

    for (int k = 0; k < 20; k++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
      $display("[TB] rand data_in=%b rst=%0b -> enc=%0d valid=%0b", data_in, rst, encoded_out, valid);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
